// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, NOP encoding
// and the {pc, instr} record carried from fetch to decode.
package ifetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with synchronous clear and occupancy count.
// Used as the granted-address queue and as the fetched-instruction buffer.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push_i && full_o && !pop_i && !clr_i));
`endif

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: credit-limited requests to instruction memory, PC tagging
// of in-order responses, buffered delivery to decode, and branch flush.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int XLEN  = ifetch_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            incr_pc_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [CW-1:0]     addr_cnt, instr_cnt;
  logic [CW-1:0]     discard_q, discard_d;
  logic [SW-1:0]     credit_used;
  logic [XLEN-1:0]   addr_head;
  logic [2*XLEN-1:0] instr_head;
  logic              addr_full, addr_empty, instr_full, instr_empty;
  logic              rsp_drop, rsp_take, instr_pop;

  assign credit_used = SW'(addr_cnt) + SW'(instr_cnt) + SW'(discard_q);
  assign imem_req_o  = rst_n_i & ~flush_i & (credit_used < SW'(DEPTH));
  assign incr_pc_o   = imem_req_o & imem_gnt_i;
  assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};

  // Words owed to flushed requests arrive first, so they are dropped before any tagging.
  assign rsp_drop  = imem_rvalid_i & (flush_i | (discard_q != '0));
  assign rsp_take  = imem_rvalid_i & ~rsp_drop;
  assign instr_pop = instr_valid_o & instr_ready_i & ~flush_i;

  always_comb begin
    discard_d = discard_q;
    if (flush_i) begin
      discard_d = discard_q + addr_cnt - CW'(imem_rvalid_i);
    end else if (imem_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) discard_q <= '0;
    else          discard_q <= discard_d;
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .push_i  (incr_pc_o),
    .data_i  (imem_addr_o),
    .pop_i   (rsp_take),
    .data_o  (addr_head),
    .count_o (addr_cnt),
    .full_o  (addr_full),
    .empty_o (addr_empty)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_q (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .push_i  (rsp_take),
    .data_i  ({addr_head, imem_rdata_i}),
    .pop_i   (instr_pop),
    .data_o  (instr_head),
    .count_o (instr_cnt),
    .full_o  (instr_full),
    .empty_o (instr_empty)
  );

  // Outputs read as zero whenever nothing is buffered, including during reset.
  assign instr_valid_o = ~instr_empty;
  assign instr_pc_o    = instr_valid_o ? instr_head[2*XLEN-1:XLEN] : '0;
  assign instr_o       = instr_valid_o ? instr_head[XLEN-1:0] : '0;
  assign busy_o        = |{addr_cnt, instr_cnt, discard_q};

`ifndef SYNTHESIS
  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    imem_rvalid_i |-> !(addr_empty && (discard_q == '0)));
  a_discard_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    discard_q <= CW'(DEPTH));
  a_addr_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(incr_pc_o && addr_full && !rsp_take));
  a_instr_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(rsp_take && instr_full && !instr_pop));
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: PC-stage and memory models drive the DUT, expected
// deliveries are queued per scenario and a monitor checks them at the decode port.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] pc_i;
  logic        incr_pc_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        busy_o;

  ifetch #(.XLEN(32), .DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pc_i          (pc_i),
    .incr_pc_o     (incr_pc_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        mq[$];
  fetch_entry_t sbq[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc, grants_left, gnt_delay, rv_lat, wait_cnt, flush_at, incr_count;
  logic [31:0] pc_next, flush_target;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    sbq.push_back(e);
  endtask

  task automatic zero_inputs();
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {28'h0, incr_pc_o, imem_req_o, instr_valid_o, busy_o}, 32'h0);
    chk({tag, "_instr"}, instr_o, 32'h0);
    chk({tag, "_pc"}, instr_pc_o, 32'h0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n_i = 1'b0;
    zero_inputs();
    mq.delete();
    #1;
    check_all_zero(tag);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    zero_inputs();
    mq.delete();
    @(negedge clk_i);
    rst_n_i      = 1'b1;
    cyc          = 0;
    flush_at     = -1;
    grants_left  = 0;
    gnt_delay    = 0;
    rv_lat       = 1;
    wait_cnt     = 0;
    incr_count   = 0;
    flush_target = 32'h0;
    pc_i         = start_pc;
    pc_next      = start_pc;
  endtask

  // One bench cycle: PC-stage update, memory response, grant decision, grant capture.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      cyc++;
      pc_i    = pc_next;
      flush_i = (cyc == flush_at);
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = {16'hC0DE, mq[0].addr[15:0]};
        void'(mq.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
      end
      imem_gnt_i = (grants_left > 0) && (wait_cnt >= gnt_delay);
      #1;
      if (incr_pc_o) begin
        mq.push_back('{imem_addr_o, cyc + rv_lat});
        grants_left--;
        incr_count++;
        wait_cnt = 0;
        $display("grant cycle=%0d addr=%h", cyc, imem_addr_o);
      end else if (imem_req_o) begin
        wait_cnt++;
      end
      pc_next = flush_i ? flush_target : (incr_pc_o ? pc_i + 32'd4 : pc_i);
    end
  endtask

  task automatic end_test(input string tag, input int n);
    run_cycles(n);
    chk({tag, "_drained"}, sbq.size(), 32'd0);
    sbq.delete();
  endtask

  // Monitor: every decode-side handshake outside a flush cycle must match the queue head.
  always @(negedge clk_i) begin
    fetch_entry_t e;
    #2;
    if (rst_n_i === 1'b1 && instr_valid_o && instr_ready_i && !flush_i) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr actual pc=%h instr=%h required=none", instr_pc_o, instr_o);
      end else begin
        e = sbq.pop_front();
        $display("deliver pc=%h instr=%h", instr_pc_o, instr_o);
        chk("instr_pc", instr_pc_o, e.pc);
        chk("instr_data", instr_o, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0;
    pc_i    = 32'h0;
    zero_inputs();
    #2;
    check_all_zero("reset");

    // Streaming with immediate grant and one-cycle memory.
    do_reset(32'h0);
    grants_left = 3; instr_ready_i = 1'b1;
    expect_instr(32'h0000_0000, 32'hC0DE_0000);
    expect_instr(32'h0000_0004, 32'hC0DE_0004);
    expect_instr(32'h0000_0008, 32'hC0DE_0008);
    run_cycles(2);
    chk("stream_no_bypass", 32'(instr_valid_o), 32'd0);
    run_cycles(1);
    chk("stream_valid_c3", 32'(instr_valid_o), 32'd1);
    chk("stream_credit_req", 32'(imem_req_o), 32'd0);
    chk("stream_busy", 32'(busy_o), 32'd1);
    run_cycles(7);
    chk("stream_grants", incr_count, 32'd3);
    end_test("stream", 2);

    // Backpressure: decode stalled, credit exhausted, then drain.
    do_reset(32'h30);
    grants_left = 4; instr_ready_i = 1'b0;
    expect_instr(32'h0000_0030, 32'hC0DE_0030);
    expect_instr(32'h0000_0034, 32'hC0DE_0034);
    expect_instr(32'h0000_0038, 32'hC0DE_0038);
    expect_instr(32'h0000_003C, 32'hC0DE_003C);
    run_cycles(5);
    chk("bp_req_low", 32'(imem_req_o), 32'd0);
    chk("bp_valid", 32'(instr_valid_o), 32'd1);
    chk("bp_hold_pc", instr_pc_o, 32'h30);
    chk("bp_hold_instr", instr_o, 32'hC0DE_0030);
    chk("bp_grants", incr_count, 32'd2);
    instr_ready_i = 1'b1;
    end_test("bp", 12);

    // Flush with two requests in flight; both responses must be discarded.
    do_reset(32'h10);
    grants_left = 4; rv_lat = 3; instr_ready_i = 1'b1;
    flush_at = 3; flush_target = 32'h40;
    expect_instr(32'h0000_0040, 32'hC0DE_0040);
    expect_instr(32'h0000_0044, 32'hC0DE_0044);
    run_cycles(3);
    chk("flush_req_low", 32'(imem_req_o), 32'd0);
    chk("flush_no_incr", 32'(incr_pc_o), 32'd0);
    run_cycles(1);
    chk("flush_busy_discard", 32'(busy_o), 32'd1);
    end_test("flush2", 12);

    // Flush in the same cycle as a buffered word and an arriving response.
    do_reset(32'h20);
    grants_left = 3; instr_ready_i = 1'b1;
    flush_at = 3; flush_target = 32'h80;
    expect_instr(32'h0000_0080, 32'hC0DE_0080);
    run_cycles(3);
    chk("flushrv_valid_in_flush", 32'(instr_valid_o), 32'd1);
    run_cycles(1);
    chk("flushrv_valid_after", 32'(instr_valid_o), 32'd0);
    chk("flushrv_idle", 32'(busy_o), 32'd0);
    end_test("flushrv", 6);

    // Slow memory: grant after three waiting cycles, response four cycles later.
    do_reset(32'h100);
    grants_left = 3; gnt_delay = 3; rv_lat = 4; instr_ready_i = 1'b1;
    expect_instr(32'h0000_0100, 32'hC0DE_0100);
    expect_instr(32'h0000_0104, 32'hC0DE_0104);
    expect_instr(32'h0000_0108, 32'hC0DE_0108);
    run_cycles(3);
    chk("slow_wait_no_incr", incr_count, 32'd0);
    chk("slow_req_held", 32'(imem_req_o), 32'd1);
    run_cycles(1);
    chk("slow_first_grant", incr_count, 32'd1);
    run_cycles(20);
    chk("slow_grants", incr_count, 32'd3);
    end_test("slow", 2);

    // Reset with two words buffered; nothing stale may follow.
    do_reset(32'h200);
    grants_left = 2; instr_ready_i = 1'b0;
    run_cycles(5);
    chk("rst_buffered_pre", 32'(instr_valid_o), 32'd1);
    async_reset("rst_buf");
    do_reset(32'h0);
    grants_left = 1; instr_ready_i = 1'b1;
    expect_instr(32'h0000_0000, 32'hC0DE_0000);
    end_test("rst_buf", 6);

    // Reset with a discard pending; the next real word must not be dropped.
    do_reset(32'h300);
    grants_left = 1; rv_lat = 4; instr_ready_i = 1'b1;
    flush_at = 2; flush_target = 32'h0;
    run_cycles(3);
    chk("rst_discard_pre", 32'(busy_o), 32'd1);
    async_reset("rst_disc");
    do_reset(32'h0);
    grants_left = 1; instr_ready_i = 1'b1;
    expect_instr(32'h0000_0000, 32'hC0DE_0000);
    end_test("rst_disc", 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
